counter_updown_mod: RTL and testbench
=====================================

// Module: counter_updown_mod
// PURPOSE
//  Parametrised successor to the fixed 8-bit free-running counter.
//  Up/down modulo-N counter with enable, synchronous clear and parallel load.
//  Flags terminal count and wrap events.
//  General timing/sequencing source for dividers, timeouts and address stepping.
// PARAMETERS
//  WIDTH      8    count register width in bits (1..32)
//  MODULUS    256  count range 0..MODULUS-1; legal range 2..2**WIDTH
//  RESET_VAL  0    value of count after rst; must be < MODULUS
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous reset, active-high
//  en        in   1      count enable; counter holds when low
//  up_dn     in   1      1 = count up, 0 = count down
//  clr       in   1      synchronous clear to 0
//  load      in   1      synchronous parallel load of load_val
//  load_val  in   WIDTH  value to load
//  count     out  WIDTH  current count (registered)
//  tc        out  1      terminal count (combinational from count, up_dn, en)
//  wrap      out  1      one-cycle pulse (registered): a wrap occurred on the last edge
//  sat       out  1      sticky saturation flag (COUNTER_SAT_EN only)
// BEHAVIOUR
//  - rst high (async):
//    - count = RESET_VAL, wrap = 0, sat = 0.
//    - Held while rst high; first update on the first clk edge after release.
//  - Per-edge priority: clr > load > en. Nothing asserted -> count holds, wrap = 0.
//  - clr:
//    - count <= 0, wrap <= 0, sat <= 0.
//    - Overrides load and en in the same cycle.
//  - load:
//    - count <= load_val; wrap <= 0.
//    - load_val >= MODULUS is clamped: MODULUS-1 is loaded.
//    - sat unchanged.
//  - en, up_dn = 1:
//    - count < MODULUS-1: count <= count + 1.
//    - count == MODULUS-1: count <= 0, wrap <= 1.
//  - en, up_dn = 0:
//    - count > 0: count <= count - 1.
//    - count == 0: count <= MODULUS-1, wrap <= 1.
//  - wrap is high for exactly one cycle per wrap event; back-to-back wraps
//    (MODULUS = 2, en held) keep it high on consecutive cycles.
//  - tc = en & ((up_dn & count == MODULUS-1) | (~up_dn & count == 0)).
//    tc high means the next edge wraps, unless clr or load intervenes.
//  - up_dn may change on any cycle and takes effect on the same edge.
//    No pipeline; latency from input to count is 1 clock.
//  - Arithmetic is performed WIDTH+1 wide. MODULUS = 2**WIDTH wraps naturally
//    with no overflow glitch.
//  - rst asserted mid-count: immediate async return to RESET_VAL.
//    Any pending wrap pulse is killed.
// CONFIGURATION
//  COUNTER_SAT_EN defined:
//   - No wrap at the terminal value. Counting up holds at MODULUS-1; counting
//     down holds at 0.
//   - sat <= 1 on the first enabled edge where count is already at the
//     terminal value in the current direction.
//   - sat is sticky until clr or rst.
//   - wrap is tied 0. tc keeps its definition: high means the next edge
//     saturates.
//  COUNTER_SAT_EN undefined: modulo wrap as above; sat is tied 0.
// TESTING  (WIDTH=8, MODULUS=10, RESET_VAL=0 unless stated)
//  1. rst=1 for 2 clk, release, en=1 up_dn=1 for 12 clk
//     -> count 1..9,0,1,2; wrap high only the cycle count=0; tc high while count=9.
//  2. From count=0: en=1 up_dn=0 for 3 clk -> count 9,8,7; wrap pulse on the 0->9 edge.
//  3. load_val=5 with load=1 & en=1 -> count=5 (load wins);
//     load_val=200 -> count=9 (clamped).
//  4. clr=1 & load=1 & en=1 with count=7 -> count=0, wrap=0.
//  5. rst pulsed mid-cycle at count=6 -> count=0 immediately, before the next clk edge.
//  6. COUNTER_SAT_EN: up 12 clk from 0 -> count sticks at 9, sat=1 after the 10th edge,
//     wrap never 1; clr -> count=0, sat=0.

Source files
------------

// File: rtl/counter_updown_if.sv
// Control/status bundle for counter_updown_mod: the driver owns the controls,
// the counter owns count and its flags.
interface counter_updown_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             sat;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  count, tc, wrap, sat
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output count, tc, wrap, sat
    );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down modulo-N counter with enable, synchronous clear, clamped parallel load,
// terminal-count and wrap flags. Define COUNTER_SAT_EN for saturating mode with sticky sat.
module counter_updown_mod #(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MODULUS   = 256,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    counter_updown_if.slave  bus
);
    localparam int unsigned      W1      = WIDTH + 1;
    localparam logic [WIDTH:0]   MAX_EXT = W1'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_inc_ext;
    logic [WIDTH:0]   w_dec_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH:0]   w_load_clamped;
    logic [WIDTH:0]   w_next_ext;
    logic [WIDTH-1:0] w_next_count;
    logic             w_unused_carry;
    logic             w_at_top;
    logic             w_at_bot;

    // One bit of headroom so MODULUS = 2**WIDTH compares and steps cleanly.
    assign w_count_ext    = {1'b0, r_count};
    assign w_inc_ext      = w_count_ext + W1'(1);
    assign w_dec_ext      = w_count_ext - W1'(1);
    assign w_load_ext     = {1'b0, bus.load_val};
    assign w_load_clamped = (w_load_ext > MAX_EXT) ? MAX_EXT : w_load_ext;
    assign w_at_top       = (w_count_ext == MAX_EXT);
    assign w_at_bot       = (r_count == '0);

    assign bus.tc = bus.en & ((bus.up_dn & w_at_top) | (~bus.up_dn & w_at_bot));

`ifdef COUNTER_SAT_EN
    logic r_sat;
    logic w_next_sat;

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_ext = w_count_ext;
        w_next_sat = r_sat;
        if (bus.clr) begin
            w_next_ext = '0;
            w_next_sat = 1'b0;
        end else if (bus.load) begin
            w_next_ext = w_load_clamped;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (w_at_top) w_next_sat = 1'b1;
                else          w_next_ext = w_inc_ext;
            end else begin
                if (w_at_bot) w_next_sat = 1'b1;
                else          w_next_ext = w_dec_ext;
            end
        end
    end

    assign w_next_count   = w_next_ext[WIDTH-1:0];
    assign w_unused_carry = w_next_ext[WIDTH];

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RST_VAL;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_sat   <= w_next_sat;
        end
    end

    assign bus.wrap = 1'b0;
    assign bus.sat  = r_sat;
`else
    logic r_wrap;
    logic w_next_wrap;

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_ext  = w_count_ext;
        w_next_wrap = 1'b0;
        if (bus.clr) begin
            w_next_ext = '0;
        end else if (bus.load) begin
            w_next_ext = w_load_clamped;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (w_at_top) begin
                    w_next_ext  = '0;
                    w_next_wrap = 1'b1;
                end else begin
                    w_next_ext  = w_inc_ext;
                end
            end else begin
                if (w_at_bot) begin
                    w_next_ext  = MAX_EXT;
                    w_next_wrap = 1'b1;
                end else begin
                    w_next_ext  = w_dec_ext;
                end
            end
        end
    end

    assign w_next_count   = w_next_ext[WIDTH-1:0];
    assign w_unused_carry = w_next_ext[WIDTH];

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RST_VAL;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_wrap  <= w_next_wrap;
        end
    end

    assign bus.wrap = r_wrap;
    assign bus.sat  = 1'b0;
`endif

    assign bus.count = r_count;
endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod (WIDTH=8, MODULUS=10, RESET_VAL=0);
// directed vectors for the wrap build, or the saturating build when COUNTER_SAT_EN is defined.
module tb_counter_updown_mod;
    typedef struct {
        string      name;
        logic [7:0] count;
        logic       wrap;
        logic       sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    counter_updown_if #(.WIDTH(8)) bus ();

    counter_updown_mod #(.WIDTH(8), .MODULUS(10), .RESET_VAL(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of controls at the falling edge, queue the post-edge expectation,
    // and check tc, which depends on the present count and the new controls.
    task automatic step(input string name, input logic en, input logic up, input logic clr,
                        input logic load, input logic [7:0] lv, input logic [7:0] e_cnt,
                        input logic e_wrap, input logic e_sat, input logic e_tc);
        exp_t e;
        @(negedge clk);
        bus.en = en; bus.up_dn = up; bus.clr = clr; bus.load = load; bus.load_val = lv;
        e.name = name; e.count = e_cnt; e.wrap = e_wrap; e.sat = e_sat;
        q.push_back(e);
        #1 check({name, ".tc"}, 32'(bus.tc), 32'(e_tc));
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear before the next edge.
    task automatic rst_pulse(input string name);
        @(negedge clk);
        bus.en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0;
        #1 rst = 1'b1;
        #1;
        check({name, ".count"}, 32'(bus.count), 32'd0);
        check({name, ".wrap"},  32'(bus.wrap),  32'd0);
        check({name, ".sat"},   32'(bus.sat),   32'd0);
        #1 rst = 1'b0;
    endtask

    // Monitor: every registered output update is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check({e.name, ".count"}, 32'(bus.count), 32'(e.count));
                check({e.name, ".wrap"},  32'(bus.wrap),  32'(e.wrap));
                check({e.name, ".sat"},   32'(bus.sat),   32'(e.sat));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.up_dn = 1'b1; bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.count", 32'(bus.count), 32'd0);
        check("reset.wrap",  32'(bus.wrap),  32'd0);
        check("reset.sat",   32'(bus.sat),   32'd0);
        check("reset.tc",    32'(bus.tc),    32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef COUNTER_SAT_EN
        // Count up from 0: sticks at 9, sat rises on the 10th edge, wrap never rises.
        for (int i = 1; i <= 12; i++)
            step("sat_up", 1, 1, 0, 0, 8'd0, (i < 9) ? 8'(i) : 8'd9, 0, (i >= 10), (i >= 10));
        step("sat_clr",   1, 1, 1, 0, 8'd0,   8'd0, 0, 0, 1);
        step("sat_dn0",   1, 0, 0, 0, 8'd0,   8'd0, 0, 1, 1);
        step("sat_load",  1, 1, 0, 1, 8'd4,   8'd4, 0, 1, 0);
        step("sat_clamp", 0, 1, 0, 1, 8'd200, 8'd9, 0, 1, 0);
        step("sat_hold",  0, 1, 0, 0, 8'd0,   8'd9, 0, 1, 0);
        rst_pulse("sat_rst");
        step("sat_dn1",   1, 0, 0, 0, 8'd0,   8'd0, 0, 1, 1);
        step("sat_clr2",  0, 1, 1, 0, 8'd0,   8'd0, 0, 0, 0);
`else
        // Up count through one wrap: 1..9,0,1,2; wrap with count=0; tc while count=9.
        for (int i = 1; i <= 12; i++)
            step("up", 1, 1, 0, 0, 8'd0, 8'(i % 10), (i == 10), 0, (i == 10));
        step("clr",      1, 1, 1, 0, 8'd0,   8'd0, 0, 0, 0);
        step("dn_wrap",  1, 0, 0, 0, 8'd0,   8'd9, 1, 0, 1);
        step("dn8",      1, 0, 0, 0, 8'd0,   8'd8, 0, 0, 0);
        step("dn7",      1, 0, 0, 0, 8'd0,   8'd7, 0, 0, 0);
        step("load5",    1, 1, 0, 1, 8'd5,   8'd5, 0, 0, 0);
        step("clamp200", 1, 1, 0, 1, 8'd200, 8'd9, 0, 0, 0);
        step("up_wrap",  1, 1, 0, 0, 8'd0,   8'd0, 1, 0, 1);
        step("clamp10",  0, 1, 0, 1, 8'd10,  8'd9, 0, 0, 0);
        step("load7",    0, 0, 0, 1, 8'd7,   8'd7, 0, 0, 0);
        step("clr_all",  1, 1, 1, 1, 8'd3,   8'd0, 0, 0, 0);
        step("load9",    0, 0, 0, 1, 8'd9,   8'd9, 0, 0, 0);
        step("clr_tc",   1, 1, 1, 0, 8'd0,   8'd0, 0, 0, 1);
        step("hold",     0, 0, 0, 0, 8'd0,   8'd0, 0, 0, 0);
        step("dir_up",   1, 1, 0, 0, 8'd0,   8'd1, 0, 0, 0);
        step("dir_dn",   1, 0, 0, 0, 8'd0,   8'd0, 0, 0, 0);
        step("dir_wrap", 1, 0, 0, 0, 8'd0,   8'd9, 1, 0, 1);
        step("load6",    0, 1, 0, 1, 8'd6,   8'd6, 0, 0, 0);
        rst_pulse("rst_mid");
        step("post_rst", 1, 0, 0, 0, 8'd0,   8'd9, 1, 0, 1);
        rst_pulse("rst_kill_wrap");
        step("post_rst2", 1, 1, 0, 0, 8'd0,  8'd1, 0, 0, 0);
`endif

        @(negedge clk);
        bus.en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #2;
        check("drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
